// File: rtl/video_test_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// video_test_pattern_gen_if
//   Video timing bundle between a raster timing source, the pattern generator
//   and the downstream TMDS encoders.
//
//   Timing side (driven by the timing source, modport master):
//     dataEnable, hSync, vSync, hPos, vPos,
//     activeVideoGuardBand, activeVideoPreamble
//   Pixel side (driven by the pattern generator, modport slave):
//     r, g, b, dataEnableDelayed, hSyncDelayed, vSyncDelayed,
//     activeVideoGuardBandDelayed, activeVideoPreambleDelayed
// -----------------------------------------------------------------------------
interface video_test_pattern_gen_if #(
  parameter int COLOR_DEPTH = 8,
  parameter int H_BITS      = 12,
  parameter int V_BITS      = 11
);
  logic                   dataEnable;
  logic                   hSync;
  logic                   vSync;
  logic [H_BITS-1:0]      hPos;
  logic [V_BITS-1:0]      vPos;
  logic                   activeVideoGuardBand;
  logic                   activeVideoPreamble;

  logic [COLOR_DEPTH-1:0] r;
  logic [COLOR_DEPTH-1:0] g;
  logic [COLOR_DEPTH-1:0] b;
  logic                   dataEnableDelayed;
  logic                   hSyncDelayed;
  logic                   vSyncDelayed;
  logic                   activeVideoGuardBandDelayed;
  logic                   activeVideoPreambleDelayed;

  modport master (
    output dataEnable, hSync, vSync, hPos, vPos,
           activeVideoGuardBand, activeVideoPreamble,
    input  r, g, b, dataEnableDelayed, hSyncDelayed, vSyncDelayed,
           activeVideoGuardBandDelayed, activeVideoPreambleDelayed
  );

  modport slave (
    input  dataEnable, hSync, vSync, hPos, vPos,
           activeVideoGuardBand, activeVideoPreamble,
    output r, g, b, dataEnableDelayed, hSyncDelayed, vSyncDelayed,
           activeVideoGuardBandDelayed, activeVideoPreambleDelayed
  );
endinterface

// File: rtl/video_test_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_test_pattern_gen
//   Multi-mode test pattern source: colour bars, gray ramp, checkerboard,
//   solid colour, scrolling bars and a one-pixel border. The pattern is
//   latched at each frame start (vSync rising) so switches never tear.
//   Pixels and timing controls both leave exactly two cycles after entry.
//
//   Ports:
//     pixelClock   - pixel clock, rising edge
//     asyncResetN  - asynchronous active-low reset
//     mode         - requested pattern, adopted at frame start
//     solidColor   - {r,g,b} for the solid pattern
//     vid          - timing in / pixels and delayed timing out (slave)
//     activeMode   - pattern currently in effect
//     frameCount   - frames since reset, free-running mod 256
// -----------------------------------------------------------------------------
module video_test_pattern_gen #(
  parameter int COLOR_DEPTH = 8,
  parameter int H_BITS      = 12,
  parameter int V_BITS      = 11,
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int CHECK_SHIFT = 5,
  parameter int RAMP_SHIFT  = 2
) (
  input  logic                     pixelClock,
  input  logic                     asyncResetN,
  input  logic [2:0]               mode,
  input  logic [3*COLOR_DEPTH-1:0] solidColor,
  video_test_pattern_gen_if.slave  vid,
  output logic [2:0]               activeMode,
  output logic [7:0]               frameCount
);

  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int COL_BITS = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  typedef enum logic [2:0] {
    MODE_BARS   = 3'd0,
    MODE_RAMP   = 3'd1,
    MODE_CHECK  = 3'd2,
    MODE_SOLID  = 3'd3,
    MODE_SCROLL = 3'd4,
    MODE_BORDER = 3'd5,
    MODE_RSVD6  = 3'd6,
    MODE_RSVD7  = 3'd7
  } pattern_e;

  typedef struct packed {
    logic [COLOR_DEPTH-1:0] r;
    logic [COLOR_DEPTH-1:0] g;
    logic [COLOR_DEPTH-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic gb;
    logic pre;
  } ctl_t;

  localparam rgb_t WHITE = '{r: '1, g: '1, b: '1};

  // Bar order white, yellow, cyan, green, magenta, red, blue, black:
  // each component is the inverse of one index bit (r<-1, g<-2, b<-0).
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    bar_colour.r = {COLOR_DEPTH{~idx[1]}};
    bar_colour.g = {COLOR_DEPTH{~idx[2]}};
    bar_colour.b = {COLOR_DEPTH{~idx[0]}};
  endfunction

  pattern_e              active_mode_q, active_mode_d;
  logic [7:0]            frame_count_q, frame_count_d;
  logic [COL_BITS-1:0]   col_cnt_q,     col_cnt_d;
  logic [2:0]            bar_idx_q,     bar_idx_d;
  ctl_t                  ctl_s1_q,      ctl_s1_d;
  ctl_t                  ctl_s2_q,      ctl_s2_d;
  rgb_t                  rgb_s1_q,      rgb_s1_d;
  rgb_t                  rgb_s2_q,      rgb_s2_d;

  ctl_t                  ctl_in;
  rgb_t                  pix;
  logic                  frame_start;
  logic [2:0]            scroll_idx;
  logic                  on_border;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    active_mode_d = active_mode_q;
    frame_count_d = frame_count_q;
    col_cnt_d     = col_cnt_q;
    bar_idx_d     = bar_idx_q;
    pix           = '0;

    ctl_in = '{de:  vid.dataEnable,
               hs:  vid.hSync,
               vs:  vid.vSync,
               gb:  vid.activeVideoGuardBand,
               pre: vid.activeVideoPreamble};

    // Stage 1 already holds the previous vSync, so it doubles as the edge
    // detector's history bit.
    frame_start = ctl_in.vs & ~ctl_s1_q.vs;
    if (frame_start) begin
      active_mode_d = pattern_e'(mode);
      frame_count_d = frame_count_q + 8'd1;
    end

    // bar_idx_q is the bar of the pixel on the inputs this cycle.
    if (!ctl_in.de) begin
      col_cnt_d = '0;
      bar_idx_d = '0;
    end else if (col_cnt_q == COL_BITS'(BAR_W - 1)) begin
      col_cnt_d = '0;
      bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
    end else begin
      col_cnt_d = col_cnt_q + COL_BITS'(1);
    end

    // Three-bit sum wraps naturally, so the frameCount wrap is seamless.
    scroll_idx = bar_idx_q + frame_count_q[2:0];
    on_border  = (vid.hPos == '0) || (vid.hPos == H_BITS'(H_ACTIVE - 1)) ||
                 (vid.vPos == '0) || (vid.vPos == V_BITS'(V_ACTIVE - 1));

    unique case (active_mode_q)
      MODE_BARS:   pix = bar_colour(bar_idx_q);
      MODE_RAMP:   pix = '{r: COLOR_DEPTH'(vid.hPos >> RAMP_SHIFT),
                           g: COLOR_DEPTH'(vid.hPos >> RAMP_SHIFT),
                           b: COLOR_DEPTH'(vid.hPos >> RAMP_SHIFT)};
      MODE_CHECK:  pix = (vid.hPos[CHECK_SHIFT] ^ vid.vPos[CHECK_SHIFT]) ? WHITE : '0;
      MODE_SOLID:  pix = rgb_t'(solidColor);
      MODE_SCROLL: pix = bar_colour(scroll_idx);
      MODE_BORDER: pix = on_border ? WHITE : '0;
      MODE_RSVD6,
      MODE_RSVD7:  pix = '0;
      default:     pix = '0;
    endcase

    // Blank here: this de becomes the delayed de that accompanies the pixel.
    rgb_s1_d = ctl_in.de ? pix : '0;
    rgb_s2_d = rgb_s1_q;
    ctl_s1_d = ctl_in;
    ctl_s2_d = ctl_s1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      active_mode_q <= MODE_BARS;
      frame_count_q <= '0;
      col_cnt_q     <= '0;
      bar_idx_q     <= '0;
      ctl_s1_q      <= '0;
      ctl_s2_q      <= '0;
      rgb_s1_q      <= '0;
      rgb_s2_q      <= '0;
    end else begin
      active_mode_q <= active_mode_d;
      frame_count_q <= frame_count_d;
      col_cnt_q     <= col_cnt_d;
      bar_idx_q     <= bar_idx_d;
      ctl_s1_q      <= ctl_s1_d;
      ctl_s2_q      <= ctl_s2_d;
      rgb_s1_q      <= rgb_s1_d;
      rgb_s2_q      <= rgb_s2_d;
    end
  end

  assign vid.r                           = rgb_s2_q.r;
  assign vid.g                           = rgb_s2_q.g;
  assign vid.b                           = rgb_s2_q.b;
  assign vid.dataEnableDelayed           = ctl_s2_q.de;
  assign vid.hSyncDelayed                = ctl_s2_q.hs;
  assign vid.vSyncDelayed                = ctl_s2_q.vs;
  assign vid.activeVideoGuardBandDelayed = ctl_s2_q.gb;
  assign vid.activeVideoPreambleDelayed  = ctl_s2_q.pre;
  assign activeMode                      = active_mode_q;
  assign frameCount                      = frame_count_q;

endmodule

// File: tb/tb_video_test_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_video_test_pattern_gen
//   Drives short synthetic frames (vSync pulse plus selected lines) into the
//   pattern generator. Each driven cycle pushes its expected delayed timing
//   and pixel onto a scoreboard; a monitor pops one entry per clock once the
//   two-cycle pipeline is primed and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_video_test_pattern_gen;

  localparam int CD = 8;
  localparam int HB = 12;
  localparam int VB = 11;
  localparam int HA = 1280;
  localparam int VA = 720;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [23:0] solid = 24'h0;
  logic [2:0]  active_mode;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  video_test_pattern_gen_if #(.COLOR_DEPTH(CD), .H_BITS(HB), .V_BITS(VB)) vif ();

  video_test_pattern_gen dut (
    .pixelClock  (clk),
    .asyncResetN (rst_n),
    .mode        (mode),
    .solidColor  (solid),
    .vid         (vif),
    .activeMode  (active_mode),
    .frameCount  (frame_count)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        gb;
    logic        pre;
    logic [23:0] rgb;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_exp;
  exp_t        mon_got;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state.
  logic [2:0]  m_mode;
  int          m_fc;
  logic        m_prev_vs;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] model_pixel(input logic de, input int h, input int v);
    int         idx;
    logic [7:0] lv;
    if (!de) return 24'h0;
    idx = h / (HA / 8);
    if (idx > 7) idx = 7;
    lv = 8'((h >> 2) & 255);
    case (m_mode)
      3'd0:    return bar_tab[idx];
      3'd1:    return {lv, lv, lv};
      3'd2:    return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      3'd3:    return solid;
      3'd4:    return bar_tab[(idx + m_fc) % 8];
      3'd5:    return (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  // One pixel-clock of stimulus; expected output queued for two cycles later.
  task automatic tick(input logic de, input logic hs, input logic vs, input int h, input int v);
    exp_t e;
    @(negedge clk);
    vif.dataEnable           = de;
    vif.hSync                = hs;
    vif.vSync                = vs;
    vif.hPos                 = HB'(h);
    vif.vPos                 = VB'(v);
    vif.activeVideoGuardBand = 1'($urandom_range(0, 1));
    vif.activeVideoPreamble  = 1'($urandom_range(0, 1));
    e.de  = de;
    e.hs  = hs;
    e.vs  = vs;
    e.gb  = vif.activeVideoGuardBand;
    e.pre = vif.activeVideoPreamble;
    e.rgb = model_pixel(de, h, v);
    if (vs && !m_prev_vs) begin
      m_mode = mode;
      m_fc++;
    end
    m_prev_vs = vs;
    sb.push_back(e);
  endtask

  task automatic frame_pulse();
    tick(1'b0, 1'b0, 1'b1, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic line(input int v, input int h_last);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 0, v);
    tick(1'b0, 1'b0, 1'b0, 0, v);
    for (int h = 0; h <= h_last; h++) tick(1'b1, 1'b0, 1'b0, h, v);
    tick(1'b0, 1'b0, 1'b0, 0, v);
  endtask

  // Scoreboard monitor: output after edge k belongs to the input of edge k-1.
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() >= 2) begin
      mon_exp = sb.pop_front();
      mon_got = {vif.dataEnableDelayed, vif.hSyncDelayed, vif.vSyncDelayed,
                 vif.activeVideoGuardBandDelayed, vif.activeVideoPreambleDelayed,
                 vif.r, vif.g, vif.b};
      n_tests++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL pixel t=%0t mode=%0d got de/hs/vs/gb/pre=%b%b%b%b%b rgb=%h, want %b%b%b%b%b rgb=%h",
                 $time, m_mode, mon_got.de, mon_got.hs, mon_got.vs, mon_got.gb, mon_got.pre,
                 mon_got.rgb, mon_exp.de, mon_exp.hs, mon_exp.vs, mon_exp.gb, mon_exp.pre,
                 mon_exp.rgb);
      end
    end
  end

  task automatic test_reset(input logic [2:0] next_mode);
    logic [36:0] outs;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    outs = {vif.r, vif.g, vif.b, vif.dataEnableDelayed, vif.hSyncDelayed, vif.vSyncDelayed,
            vif.activeVideoGuardBandDelayed, vif.activeVideoPreambleDelayed, frame_count};
    n_tests++;
    if (outs !== 37'h0 || active_mode !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_immediate got outs=%h mode=%0d, want 0 0", outs, active_mode);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vif.dataEnable           = 1'($urandom_range(0, 1));
      vif.hSync                = 1'($urandom_range(0, 1));
      vif.vSync                = 1'($urandom_range(0, 1));
      vif.hPos                 = HB'($urandom_range(0, HA - 1));
      vif.vPos                 = VB'($urandom_range(0, VA - 1));
      vif.activeVideoGuardBand = 1'($urandom_range(0, 1));
      vif.activeVideoPreamble  = 1'($urandom_range(0, 1));
      mode                     = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1;
    outs = {vif.r, vif.g, vif.b, vif.dataEnableDelayed, vif.hSyncDelayed, vif.vSyncDelayed,
            vif.activeVideoGuardBandDelayed, vif.activeVideoPreambleDelayed, frame_count};
    n_tests++;
    if (outs !== 37'h0 || active_mode !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_held got outs=%h mode=%0d, want 0 0", outs, active_mode);
    end
    @(negedge clk);
    vif.dataEnable = 1'b0;
    vif.hSync      = 1'b0;
    vif.vSync      = 1'b0;
    mode           = next_mode;
    m_mode         = 3'd0;
    m_fc           = 0;
    m_prev_vs      = 1'b0;
    rst_n          = 1'b1;
    // Partial line before any vSync: must still be drawn with mode 0.
    line(100, 5);
    n_tests++;
    if (active_mode !== 3'd0) begin
      n_fail++;
      $display("FAIL release_mode got %0d, want 0", active_mode);
    end
    frame_pulse();
    n_tests++;
    if (active_mode !== next_mode || frame_count !== 8'd1) begin
      n_fail++;
      $display("FAIL adopt_after_reset got mode=%0d fc=%0d, want mode=%0d fc=1",
               active_mode, frame_count, next_mode);
    end
    line(200, 5);
  endtask

  task automatic test_colour_bars();
    mode = 3'd0;
    frame_pulse();
    line(0, HA - 1);
    line(1, 200);
  endtask

  task automatic test_mode_switch();
    mode = 3'd0;
    frame_pulse();
    line(299, 63);
    mode = 3'd2;
    line(300, 63);
    line(301, 63);
    n_tests++;
    if (active_mode !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_frame_mode got %0d, want 0", active_mode);
    end
    frame_pulse();
    n_tests++;
    if (active_mode !== 3'd2) begin
      n_fail++;
      $display("FAIL next_frame_mode got %0d, want 2", active_mode);
    end
    line(0, 63);
    line(32, 63);
  endtask

  task automatic test_scroll();
    mode = 3'd4;
    // Fast-forward frameCount so the nine frames below cross 255 -> 0.
    while (m_fc < 250) begin
      tick(1'b0, 1'b0, 1'b1, 0, 0);
      tick(1'b0, 1'b0, 1'b0, 0, 0);
    end
    for (int f = 0; f < 9; f++) begin
      frame_pulse();
      n_tests++;
      if (frame_count !== 8'(m_fc % 256) || active_mode !== 3'd4) begin
        n_fail++;
        $display("FAIL scroll_frame%0d got fc=%0d mode=%0d, want fc=%0d mode=4",
                 f, frame_count, active_mode, m_fc % 256);
      end
      line(10, 3);
    end
  endtask

  task automatic test_solid();
    mode  = 3'd3;
    solid = 24'h123456;
    frame_pulse();
    line(5, 20);
    solid = 24'hA5C30F;
    line(6, 8);
  endtask

  task automatic test_border_reserved();
    mode = 3'd5;
    frame_pulse();
    line(0, HA - 1);
    line(1, 3);
    line(VA - 1, HA - 1);
    mode = 3'd7;
    frame_pulse();
    n_tests++;
    if (active_mode !== 3'd7) begin
      n_fail++;
      $display("FAIL reserved_mode got %0d, want 7", active_mode);
    end
    line(2, 15);
    line(3, 15);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vif.dataEnable           = 1'b0;
    vif.hSync                = 1'b0;
    vif.vSync                = 1'b0;
    vif.hPos                 = '0;
    vif.vPos                 = '0;
    vif.activeVideoGuardBand = 1'b0;
    vif.activeVideoPreamble  = 1'b0;
    m_mode                   = 3'd0;
    m_fc                     = 0;
    m_prev_vs                = 1'b0;

    test_reset(3'd1);
    test_colour_bars();
    test_mode_switch();
    test_scroll();
    test_solid();
    test_border_reserved();
    // Reset dropped mid-line: next pattern only after the first vSync edge.
    mode = 3'd7;
    line(50, 10);
    test_reset(3'd5);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
